rect_fill_writer: RTL

RECT_FILL_WRITER -- requirements
Module: rect_fill_writer

---
 rtl/rect_fill_writer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/rect_fill_writer.sv
// rect_fill_writer: clears the back buffer and fills clipped rectangles
// of blocks, one frame-buffer write per cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   frame_start       buffer-swap pulse; restarts (and may clear) the frame
//   clear_en          clear the buffer when frame_start arrives
//   clear_color       clear colour, sampled at frame_start
//   cmd_valid/ready   rectangle command handshake
//   cmd_x, cmd_y      top-left block of the rectangle
//   cmd_w, cmd_h      rectangle size in blocks
//   cmd_color         fill colour
//   wr_en/addr/data   frame-buffer write port, addr = row*GRID_W + col
//   busy              clearing or filling
//   overrun           one-cycle pulse when frame_start cut work short
module rect_fill_writer #(
  parameter int GRID_W     = 32,
  parameter int GRID_H     = 24,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  clear_en,
  input  logic [7:0]            clear_color,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [4:0]            cmd_x,
  input  logic [4:0]            cmd_y,
  input  logic [5:0]            cmd_w,
  input  logic [5:0]            cmd_h,
  input  logic [7:0]            cmd_color,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    READY,
    FILL
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] GW = CW'(GRID_W);
  localparam logic [CW-1:0] GH = CW'(GRID_H);
  localparam logic [ADDR_WIDTH-1:0] GW_A = ADDR_WIDTH'(GRID_W);
  localparam logic [ADDR_WIDTH-1:0] LAST_A =
    ADDR_WIDTH'(GRID_W * GRID_H - 1);

  state_t state;

  logic rdy_q;
  logic wr_q;

  logic [CW-1:0]         x_q;
  logic [CW-1:0]         col;
  logic [CW-1:0]         row;
  logic [CW-1:0]         col_end;
  logic [CW-1:0]         row_end;
  logic [ADDR_WIDTH-1:0] row_base;

  // command decode, widened so x+w / y+h never wrap
  logic [CW-1:0]         x_ext;
  logic [CW-1:0]         y_ext;
  logic [CW-1:0]         sum_x;
  logic [CW-1:0]         sum_y;
  logic [CW-1:0]         ce_n;
  logic [CW-1:0]         re_n;
  logic                  cmd_empty;
  logic [ADDR_WIDTH-1:0] base_n;

  assign x_ext  = CW'(cmd_x);
  assign y_ext  = CW'(cmd_y);
  assign sum_x  = x_ext + CW'(cmd_w);
  assign sum_y  = y_ext + CW'(cmd_h);
  assign ce_n   = (sum_x > GW) ? GW : sum_x;
  assign re_n   = (sum_y > GH) ? GH : sum_y;
  assign base_n = ADDR_WIDTH'(cmd_y) * GW_A;

  assign cmd_empty = (cmd_w == 6'd0) || (cmd_h == 6'd0) ||
                     (x_ext >= GW) || (y_ext >= GH);

  // raster stepping
  logic [CW-1:0]         col_nx;
  logic [CW-1:0]         row_nx;
  logic [ADDR_WIDTH-1:0] base_nx;

  assign col_nx  = col + 1'b1;
  assign row_nx  = row + 1'b1;
  assign base_nx = row_base + GW_A;

  // frame_start must block the handshake and the write in its own
  // cycle, so both strobes are gated combinationally
  assign cmd_ready = rdy_q & ~frame_start;
  assign wr_en     = wr_q & ~frame_start;
  assign busy      = (state == CLEAR) || (state == FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rdy_q    <= 1'b0;
      wr_q     <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      overrun  <= 1'b0;
      x_q      <= '0;
      col      <= '0;
      row      <= '0;
      col_end  <= '0;
      row_end  <= '0;
      row_base <= '0;
    end else begin
      overrun <= 1'b0;
      if (frame_start) begin
        overrun <= (state == CLEAR) || (state == FILL);
        wr_addr <= '0;
        wr_data <= clear_color;
        if (clear_en) begin
          state <= CLEAR;
          wr_q  <= 1'b1;
          rdy_q <= 1'b0;
        end else begin
          state <= READY;
          wr_q  <= 1'b0;
          rdy_q <= 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: begin
            rdy_q <= 1'b0;
            wr_q  <= 1'b0;
          end
          CLEAR: begin
            if (wr_addr == LAST_A) begin
              state <= READY;
              wr_q  <= 1'b0;
              rdy_q <= 1'b1;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
          READY: begin
            if (cmd_valid && !cmd_empty) begin
              state    <= FILL;
              rdy_q    <= 1'b0;
              wr_q     <= 1'b1;
              wr_addr  <= base_n + ADDR_WIDTH'(cmd_x);
              wr_data  <= cmd_color;
              x_q      <= x_ext;
              col      <= x_ext;
              row      <= y_ext;
              col_end  <= ce_n;
              row_end  <= re_n;
              row_base <= base_n;
            end
          end
          FILL: begin
            if (col_nx < col_end) begin
              col     <= col_nx;
              wr_addr <= wr_addr + 1'b1;
            end else if (row_nx < row_end) begin
              row      <= row_nx;
              col      <= x_q;
              row_base <= base_nx;
              wr_addr  <= base_nx + ADDR_WIDTH'(x_q);
            end else begin
              state <= READY;
              wr_q  <= 1'b0;
              rdy_q <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            rdy_q <= 1'b0;
            wr_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
